// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch slice.
// Holds reset PC, nop encoding, next-PC selector codes and FSM states.
package instr_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    localparam logic [2:0] NPC_BEQ = 3'd0;
    localparam logic [2:0] NPC_J   = 3'd1;
    localparam logic [2:0] NPC_JR  = 3'd2;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_npc_calc.sv
// Combinational next-PC selection for beq, j/jal and jr.
// Reserved selector codes fall back to sequential fetch.
module npc_calc
    import instr_fetch_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [25:0] imm26_i,
    input  logic        branch_jump_i,
    input  logic [2:0]  npc_sel_i,
    input  logic        cmp_true_i,
    input  logic [31:0] rs_data_i,
    output logic [31:0] npc_o
);

    logic [31:0] pc4;
    logic [31:0] br_off;

    assign pc4    = pc_i + 32'd4;
    assign br_off = {{14{imm26_i[15]}}, imm26_i[15:0], 2'b00};

    // pc_i already points at the delay slot, i.e. the branch's PC+4
    always_comb begin
        npc_o = pc4;
        if (branch_jump_i) begin
            case (npc_sel_i)
                NPC_BEQ: if (cmp_true_i) npc_o = pc_i + br_off;
                NPC_J:   npc_o = {pc_i[31:28], imm26_i, 2'b00};
                NPC_JR:  npc_o = rs_data_i;
                default: npc_o = pc4;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, IF/ID register and BOOT/RUN/HALT control.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt/stall_cnt counters.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_jump,
    input  logic [2:0]  npc_sel,
    input  logic        cmp_true,
    input  logic [31:0] rs_data,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8,
    output logic [5:0]  id_op,
    output logic [5:0]  id_func,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
`endif
    output logic        halted
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  id_instr_q;
    logic [31:0]  id_pc_q;
    logic         halted_q;
    logic [31:0]  npc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

    npc_calc u_npc_calc (
        .pc_i          (pc_q),
        .imm26_i       (id_instr_q[25:0]),
        .branch_jump_i (branch_jump),
        .npc_sel_i     (npc_sel),
        .cmp_true_i    (cmp_true),
        .rs_data_i     (rs_data),
        .npc_o         (npc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            id_instr_q <= NOP;
            id_pc_q    <= RESET_PC;
            halted_q   <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_BOOT: begin
                    id_instr_q <= NOP;
                    state_q    <= ST_RUN;
                end
                ST_RUN: begin
                    if (stall) begin
`ifdef FETCH_PERF_CNT_EN
                        stall_cnt_q <= stall_cnt_q + 32'd1;
`endif
                    end else begin
`ifdef FETCH_PERF_CNT_EN
                        fetch_cnt_q <= fetch_cnt_q + 32'd1;
`endif
                        // misaligned target: freeze PC, squash IF/ID
                        if (npc[1:0] != 2'b00) begin
                            state_q    <= ST_HALT;
                            halted_q   <= 1'b1;
                            id_instr_q <= NOP;
                        end else begin
                            pc_q       <= npc;
                            id_instr_q <= imem_rdata;
                            id_pc_q    <= pc_q;
                        end
                    end
                end
                ST_HALT: begin
                    id_instr_q <= NOP;
                end
                default: begin
                    state_q <= ST_HALT;
                end
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign id_pc8    = id_pc_q + 32'd8;
    assign id_op     = id_instr_q[31:26];
    assign id_func   = id_instr_q[5:0];
    assign halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit.
// A cycle-level reference model predicts outputs; a monitor compares.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_jump;
    logic [2:0]  npc_sel;
    logic        cmp_true;
    logic [31:0] rs_data;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic [5:0]  id_op;
    logic [5:0]  id_func;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [5:0]  op;
        logic [5:0]  func;
        logic        hlt;
        logic [31:0] fcnt;
        logic [31:0] scnt;
    } obs_t;

    obs_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // model state
    logic [31:0] m_pc, m_instr, m_idpc, m_fc, m_sc;
    int          m_mode; // 0 boot, 1 run, 2 halt

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .branch_jump (branch_jump),
        .npc_sel     (npc_sel),
        .cmp_true    (cmp_true),
        .rs_data     (rs_data),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc8      (id_pc8),
        .id_op       (id_op),
        .id_func     (id_func),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt),
`endif
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a ^ 32'h5A5A_1234) * 32'h9E37_79B1) ^ (a >> 7);
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    function automatic obs_t model_obs();
        obs_t o;
        o.addr  = m_pc;
        o.instr = m_instr;
        o.pc    = m_idpc;
        o.pc8   = m_idpc + 32'd8;
        o.op    = 6'(m_instr / 32'h0400_0000);
        o.func  = 6'(m_instr % 64);
        o.hlt   = (m_mode == 2);
        o.fcnt  = m_fc;
        o.scnt  = m_sc;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.addr  = imem_addr;
        o.instr = id_instr;
        o.pc    = id_pc;
        o.pc8   = id_pc8;
        o.op    = id_op;
        o.func  = id_func;
        o.hlt   = halted;
`ifdef FETCH_PERF_CNT_EN
        o.fcnt  = fetch_cnt;
        o.scnt  = stall_cnt;
`else
        o.fcnt  = m_fc;
        o.scnt  = m_sc;
`endif
        return o;
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0000_3000;
        m_instr = 32'h0;
        m_idpc  = 32'h0000_3000;
        m_mode  = 0;
        m_fc    = 0;
        m_sc    = 0;
    endtask

    // one clock of architectural behaviour
    task automatic model_step();
        logic [31:0] target;
        int          s;
        if (m_mode == 0) begin
            m_instr = 32'h0;
            m_mode  = 1;
        end else if (m_mode == 2) begin
            m_instr = 32'h0;
        end else if (stall) begin
            m_sc = m_sc + 1;
        end else begin
            m_fc = m_fc + 1;
            target = m_pc + 4;
            if (branch_jump) begin
                if (npc_sel == 0 && cmp_true) begin
                    s = int'(m_instr % 65536);
                    if (s >= 32768) s = s - 65536;
                    target = m_pc + 32'(s * 4);
                end else if (npc_sel == 1) begin
                    target = (m_pc & 32'hF000_0000) | ((m_instr % 32'h0400_0000) * 4);
                end else if (npc_sel == 2) begin
                    target = rs_data;
                end
            end
            if (target % 4 != 0) begin
                m_mode  = 2;
                m_instr = 32'h0;
            end else begin
                m_instr = mem_word(m_pc);
                m_idpc  = m_pc;
                m_pc    = target;
            end
        end
    endtask

    task automatic compare(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got addr=%h instr=%h pc=%h pc8=%h op=%h fn=%h h=%b fc=%0d sc=%0d exp addr=%h instr=%h pc=%h pc8=%h op=%h fn=%h h=%b fc=%0d sc=%0d",
                     name, $time, got.addr, got.instr, got.pc, got.pc8, got.op, got.func, got.hlt, got.fcnt, got.scnt,
                     exp.addr, exp.instr, exp.pc, exp.pc8, exp.op, exp.func, exp.hlt, exp.fcnt, exp.scnt);
        end
    endtask

    // monitor: compare after every active edge where a prediction exists
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare("cycle", dut_obs(), e);
            end
        end
    end

    task automatic drive_random();
        int r;
        stall       = ($urandom_range(0, 3) == 0);
        branch_jump = ($urandom_range(0, 4) < 2);
        cmp_true    = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 9);
        if (r < 4)      npc_sel = 3'd0;
        else if (r < 7) npc_sel = 3'd1;
        else if (r < 9) npc_sel = 3'd2;
        else            npc_sel = 3'($urandom_range(3, 7));
        r = $urandom_range(0, 19);
        if (r == 0)      rs_data = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
        else if (r == 1) rs_data = 32'hFFFF_FFFC;
        else if (r == 2) rs_data = 32'hFFFF_FFF8;
        else             rs_data = 32'h0000_3000 + 32'($urandom_range(0, 255) * 4);
    endtask

    initial begin
        reset       = 1'b0;
        stall       = 1'b0;
        branch_jump = 1'b0;
        npc_sel     = 3'd0;
        cmp_true    = 1'b0;
        rs_data     = 32'h0;
        model_reset();
        @(negedge clk);
        for (int ep = 0; ep < 20; ep++) begin
            reset = 1'b0;
            model_reset();
            #1;
            compare("reset", dut_obs(), model_obs());
            @(negedge clk);
            compare("reset_hold", dut_obs(), model_obs());
            reset = 1'b1;
            for (int c = 0; c < int'($urandom_range(60, 150)); c++) begin
                drive_random();
                model_step();
                exp_q.push_back(model_obs());
                @(negedge clk);
            end
        end
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
